// File: rtl/seqdet_pkg.sv
// seqdet_pkg: shared constants, FSM state type and target symbol table for sequence_detector
package seqdet_pkg;
  localparam int DATA_W = 3;
  localparam int SEQ_LEN = 8;
  localparam int CNT_W = 8;
  // Sn: the first n target symbols have been matched by the most recent inputs
  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} state_t;
  // Target sequence, oldest symbol at index 0
  localparam logic [DATA_W-1:0] SEQ_SYM [SEQ_LEN] = '{
    3'b001, 3'b101, 3'b110, 3'b000, 3'b110, 3'b110, 3'b011, 3'b101
  };
endpackage

// File: rtl/seqdet_match_counter.sv
// seqdet_match_counter: saturating detection counter
//   clk     - clock
//   reset_n - asynchronous active-low reset, clears count
//   inc     - count one detection on this edge
//   count   - detections so far, holds at all-ones
module seqdet_match_counter
  import seqdet_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/sequence_detector.sv
// sequence_detector: Mealy detector for the 8-symbol target sequence in seqdet_pkg
//   clk            - clock, state updates on rising edge
//   reset_n        - asynchronous active-low reset, state to S0
//   data_in        - one 3-bit symbol per clock
//   sequence_found - high while data_in completes the sequence (combinational)
//   match_count    - saturating detection count, only when SEQDET_COUNT_EN is defined
module sequence_detector
  import seqdet_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  output logic              sequence_found
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0]  match_count
`endif
);
  state_t state;
  state_t state_nxt;
  logic   sym_hit;
  // The first symbol never recurs later in the sequence, so on any mismatch the
  // only useful overlap is the current symbol restarting a match as S1.
  always_comb begin
    sym_hit   = data_in == SEQ_SYM[state];
    state_nxt = (sym_hit && state != S7) ? state_t'(state + 3'd1)
              : (data_in == SEQ_SYM[0] ? S1 : S0);
  end
  assign sequence_found = state == S7 && data_in == SEQ_SYM[SEQ_LEN-1];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S0;
    else state <= state_nxt;
`ifdef SEQDET_COUNT_EN
  seqdet_match_counter u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (sequence_found),
    .count   (match_count)
  );
`endif
endmodule

// File: tb/tb_sequence_detector.sv
// tb_sequence_detector: directed and randomized checks against a sliding-window reference model
module tb_sequence_detector;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] data_in = 3'b000;
  logic       sequence_found;
`ifdef SEQDET_COUNT_EN
  logic [7:0] match_count;
`endif
  int passed = 0;
  int total = 0;
  logic [2:0] tgt [8] = '{3'b001, 3'b101, 3'b110, 3'b000, 3'b110, 3'b110, 3'b011, 3'b101};
  logic [2:0] hist [$];
  int model_cnt = 0;

  always #5 clk = ~clk;

  sequence_detector dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .data_in        (data_in),
    .sequence_found (sequence_found)
`ifdef SEQDET_COUNT_EN
    ,
    .match_count    (match_count)
`endif
  );

  // Reference: a hit means the seven symbols sampled since reset just before
  // this one equal the target prefix and the current symbol is the last one.
  function automatic bit model_hit(input logic [2:0] s);
    if (hist.size() < 7) return 1'b0;
    for (int i = 0; i < 7; i++)
      if (hist[hist.size() - 7 + i] !== tgt[i]) return 1'b0;
    return s == tgt[7];
  endfunction

  task automatic step(input logic [2:0] s, output logic got, output logic exp);
    @(negedge clk);
    data_in = s;
    #1;
    got = sequence_found;
    exp = model_hit(s);
    @(posedge clk);
    if (exp && model_cnt < 255) model_cnt++;
    hist.push_back(s);
    if (hist.size() > 7) void'(hist.pop_front());
  endtask

  task automatic test_reset();
    logic g, e;
    total++;
    if (sequence_found !== 1'b0) $display("FAIL reset_found got %b exp 0", sequence_found);
    else passed++;
    data_in = 3'b101;
    #1;
    total++;
    if (sequence_found !== 1'b0) $display("FAIL reset_found_101 got %b exp 0", sequence_found);
    else passed++;
`ifdef SEQDET_COUNT_EN
    total++;
    if (match_count !== 8'd0) $display("FAIL reset_count got %0d exp 0", match_count);
    else passed++;
`endif
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) step(tgt[i], g, e);
    @(negedge clk);
    data_in = 3'b101;
    #1;
    total++;
    if (sequence_found !== 1'b1) $display("FAIL pre_async_found got %b exp 1", sequence_found);
    else passed++;
    reset_n = 1'b0;
    hist.delete();
    model_cnt = 0;
    #1;
    total++;
    if (sequence_found !== 1'b0) $display("FAIL async_reset_found got %b exp 0", sequence_found);
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    logic g, e;
    for (int i = 0; i < 9; i++) begin
      step(i < 8 ? tgt[i] : 3'b000, g, e);
      total++;
      if (g !== (i == 7)) $display("FAIL single_step%0d got %b exp %b", i, g, i == 7);
      else passed++;
    end
`ifdef SEQDET_COUNT_EN
    total++;
    if (match_count !== 8'd1) $display("FAIL single_count got %0d exp 1", match_count);
    else passed++;
`endif
  endtask

  task automatic test_bad_last();
    logic g, e;
    for (int i = 0; i < 8; i++) begin
      step(i < 7 ? tgt[i] : 3'b100, g, e);
      total++;
      if (g !== 1'b0) $display("FAIL bad_last_step%0d got %b exp 0", i, g);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic g, e;
    int pulses = 0;
    int first = -1;
    int last = -1;
    int c0 = model_cnt;
    for (int i = 0; i < 16; i++) begin
      step(tgt[i % 8], g, e);
      total++;
      if (g !== (i == 7 || i == 15)) $display("FAIL b2b_step%0d got %b exp %b", i, g, i == 7 || i == 15);
      else passed++;
      if (g === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        last = i;
      end
    end
    total++;
    if (pulses != 2 || last - first != 8) $display("FAIL b2b_pulses got %0d gap %0d exp 2 gap 8", pulses, last - first);
    else passed++;
`ifdef SEQDET_COUNT_EN
    total++;
    if (match_count !== 8'(c0 + 2)) $display("FAIL b2b_count got %0d exp %0d", match_count, c0 + 2);
    else passed++;
`endif
  endtask

  task automatic test_reset_mid();
    logic g, e;
    step(tgt[0], g, e);
    step(tgt[1], g, e);
    @(negedge clk);
    reset_n = 1'b0;
    hist.delete();
    model_cnt = 0;
    @(negedge clk);
`ifdef SEQDET_COUNT_EN
    total++;
    if (match_count !== 8'd0) $display("FAIL mid_reset_count got %0d exp 0", match_count);
    else passed++;
`endif
    reset_n = 1'b1;
    for (int i = 2; i < 8; i++) begin
      step(tgt[i], g, e);
      total++;
      if (g !== 1'b0) $display("FAIL mid_reset_step%0d got %b exp 0", i, g);
      else passed++;
    end
  endtask

  task automatic test_fallback();
    logic g, e;
    for (int i = 0; i < 9; i++) begin
      step(i == 0 ? 3'b001 : tgt[i - 1], g, e);
      total++;
      if (g !== (i == 8)) $display("FAIL fallback_step%0d got %b exp %b", i, g, i == 8);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic g, e;
    logic [2:0] s;
    int n;
    int bad;
    for (int c = 0; c < 80; c++) begin
      case ($urandom_range(0, 3))
        0: n = 8;
        1: n = $urandom_range(1, 7);
        2: n = -int'($urandom_range(1, 4));
        default: n = 8;
      endcase
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      for (int i = 0; i < (n < 0 ? -n : n); i++) begin
        s = (n < 0) ? 3'($urandom) : (i == bad ? 3'($urandom) : tgt[i]);
        step(s, g, e);
        total++;
        if (g !== e) $display("FAIL random_c%0d_i%0d sym %b got %b exp %b", c, i, s, g, e);
        else passed++;
      end
    end
`ifdef SEQDET_COUNT_EN
    total++;
    if (match_count !== 8'(model_cnt)) $display("FAIL random_count got %0d exp %0d", match_count, model_cnt);
    else passed++;
`endif
  endtask

`ifdef SEQDET_COUNT_EN
  task automatic test_saturate();
    logic g, e;
    for (int r = 0; r < 260; r++)
      for (int i = 0; i < 8; i++) step(tgt[i], g, e);
    total++;
    if (match_count !== 8'd255 || model_cnt != 255) $display("FAIL saturate_count got %0d exp 255", match_count);
    else passed++;
  endtask
`endif

  initial begin
    #2;
    test_reset();
    test_single();
    test_bad_last();
    test_back_to_back();
    test_reset_mid();
    test_fallback();
    test_random();
`ifdef SEQDET_COUNT_EN
    test_saturate();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
